// File: rtl/random_pool_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : random_pool_reader_pkg
// Brief    : Shared widths and state encoding for the randomness pool reader.
// Revision : 1.0
// ============================================================================
package random_pool_reader_pkg;

    localparam int POOL_WIDTH_DEFAULT = 512;
    localparam int WORD_WIDTH_DEFAULT = 32;
    localparam int WORDS_PER_POOL     = POOL_WIDTH_DEFAULT / WORD_WIDTH_DEFAULT;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_LOADED = 1'b1;

    // Width of a words-remaining counter that can hold the full word count.
    function automatic int left_width(input int pool_w, input int word_w);
        return $clog2(pool_w / word_w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/random_pool_reader_pool_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : pool_shift_reg
// Brief    : Load/shift register for the pool; consumed words zero-filled.
// Revision : 1.0
// ============================================================================
module pool_shift_reg
    import random_pool_reader_pkg::*;
#(
    parameter int POOL_WIDTH = POOL_WIDTH_DEFAULT,
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int LEFT_WIDTH = left_width(POOL_WIDTH, WORD_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [POOL_WIDTH-1:0] pool_in,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic [LEFT_WIDTH-1:0] words_left
);

    localparam logic [LEFT_WIDTH-1:0] c_full = LEFT_WIDTH'(POOL_WIDTH / WORD_WIDTH);
    localparam logic [LEFT_WIDTH-1:0] c_one  = {{(LEFT_WIDTH-1){1'b0}}, 1'b1};

    logic [POOL_WIDTH-1:0] r_sreg;
    logic [LEFT_WIDTH-1:0] r_left;

    // Load beats shift so a coincident new pool lands unshifted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sreg <= '0;
            r_left <= '0;
        end else if (load) begin
            r_sreg <= pool_in;
            r_left <= c_full;
        end else if (shift && (r_left != '0)) begin
            r_sreg <= r_sreg >> WORD_WIDTH;
            r_left <= r_left - c_one;
        end
    end

    assign word_out   = r_sreg[WORD_WIDTH-1:0];
    assign words_left = r_left;

endmodule
`default_nettype wire

// File: rtl/random_pool_reader.sv
`default_nettype none
// ============================================================================
// Module   : random_pool_reader
// Brief    : Captures the extractor pool and streams it out word by word.
// Revision : 1.0
// ============================================================================
module random_pool_reader
    import random_pool_reader_pkg::*;
#(
    parameter int POOL_WIDTH = POOL_WIDTH_DEFAULT,
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          pool_ready,
    input  logic [POOL_WIDTH-1:0]                         pool,
    output logic                                          word_valid,
    input  logic                                          word_ready,
    output logic [WORD_WIDTH-1:0]                         word,
    output logic [left_width(POOL_WIDTH, WORD_WIDTH)-1:0] words_left,
    output logic                                          empty,
    output logic                                          overrun,
    output logic [CNT_WIDTH-1:0]                          pools_received
);

    localparam int                      c_left_width = left_width(POOL_WIDTH, WORD_WIDTH);
    localparam logic [c_left_width-1:0] c_left_one   = {{(c_left_width-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    c_cnt_one    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]              r_state;
    logic                    r_overrun;
    logic [CNT_WIDTH-1:0]    r_pools;

    logic                    w_consume;
    logic                    w_shift;
    logic                    w_last;
    logic                    w_overrun_evt;
    logic [c_left_width-1:0] w_words_left;
    logic [WORD_WIDTH-1:0]   w_word;

    assign w_consume = (r_state == ST_LOADED) && word_ready;
    assign w_shift   = w_consume && !pool_ready;
    assign w_last    = (w_words_left == c_left_one);

    // Undelivered old words are lost when a new pool arrives.
    assign w_overrun_evt = pool_ready &&
                           ((w_words_left > c_left_one) || (w_last && !word_ready));

    pool_shift_reg #(
        .POOL_WIDTH (POOL_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .LEFT_WIDTH (c_left_width)
    ) u_shift_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (pool_ready),
        .shift      (w_shift),
        .pool_in    (pool),
        .word_out   (w_word),
        .words_left (w_words_left)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else if (pool_ready) begin
            r_state <= ST_LOADED;
        end else if (w_shift && w_last) begin
            r_state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_pools   <= '0;
        end else begin
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end
            if (pool_ready && (r_pools != '1)) begin
                r_pools <= r_pools + c_cnt_one;
            end
        end
    end

    assign word_valid     = (r_state == ST_LOADED);
    assign empty          = (r_state == ST_EMPTY);
    assign word           = w_word;
    assign words_left     = w_words_left;
    assign overrun        = r_overrun;
    assign pools_received = r_pools;

endmodule
`default_nettype wire

// File: tb/tb_random_pool_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_random_pool_reader
// Brief    : Directed vector bench for random_pool_reader.
// Revision : 1.0
// ============================================================================
module tb_random_pool_reader;

    localparam int PW = 512;
    localparam int WW = 32;
    localparam int LW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pool_ready = 1'b0;
    logic [PW-1:0] pool = '0;
    logic          word_ready = 1'b0;
    logic          word_valid;
    logic [WW-1:0] word;
    logic [LW-1:0] words_left;
    logic          empty;
    logic          overrun;
    logic [15:0]   pools_received;

    logic          reset2 = 1'b0;
    logic          pool_ready2 = 1'b0;
    logic [PW-1:0] pool2 = '0;
    logic          word_ready2 = 1'b0;
    logic          word_valid2;
    logic [WW-1:0] word2;
    logic [LW-1:0] words_left2;
    logic          empty2;
    logic          overrun2;
    logic [3:0]    pools_received2;

    random_pool_reader dut (
        .clock(clock), .reset(reset), .pool_ready(pool_ready), .pool(pool),
        .word_valid(word_valid), .word_ready(word_ready), .word(word),
        .words_left(words_left), .empty(empty), .overrun(overrun),
        .pools_received(pools_received)
    );

    random_pool_reader #(.CNT_WIDTH(4)) dut_sat (
        .clock(clock), .reset(reset2), .pool_ready(pool_ready2), .pool(pool2),
        .word_valid(word_valid2), .word_ready(word_ready2), .word(word2),
        .words_left(words_left2), .empty(empty2), .overrun(overrun2),
        .pools_received(pools_received2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        pr;
        int          pid;
        logic        wr;
        int          reps;
        logic        ev;
        logic [31:0] ew;
        int          el;
        logic        eo;
        int          ec;
    } vec_t;

    vec_t          tbl[$];
    logic [PW-1:0] pools[3];
    int            n_checks = 0;
    int            n_pass   = 0;

    // Pool 0: word k = k; pool 1: 0xB000_00kk; pool 2: 0xC000_00kk.
    function automatic logic [31:0] exp_word(input int pid, input int k);
        logic [31:0] kw;
        kw = 32'(k);
        case (pid)
            0:       return kw;
            1:       return 32'hB000_0000 | kw;
            default: return 32'hC000_0000 | kw;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic pr, input int pid, input logic wr, input int reps,
                       input logic ev, input logic [31:0] ew, input int el, input logic eo, input int ec);
        vec_t v;
        v.rst = rst; v.pr = pr; v.pid = pid; v.wr = wr; v.reps = reps;
        v.ev = ev; v.ew = ew; v.el = el; v.eo = eo; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic pr, input int pid, input logic wr);
        reset      = rst;
        pool_ready = pr;
        pool       = pools[pid];
        word_ready = wr;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        pool_ready = 1'b0;
        word_ready = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [31:0] ew,
                              input int el, input logic eo, input int ec);
        check({tag, " word_valid"}, 64'(word_valid), 64'(ev));
        check({tag, " empty"}, 64'(empty), 64'(!ev));
        check({tag, " word"}, 64'(word), 64'(ew));
        check({tag, " words_left"}, 64'(words_left), 64'(el));
        check({tag, " overrun"}, 64'(overrun), 64'(eo));
        check({tag, " pools_received"}, 64'(pools_received), 64'(ec));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                drive(tbl[i].rst, tbl[i].pr, tbl[i].pid, tbl[i].wr);
                expect_out($sformatf("row%0d.%0d", i, r), tbl[i].ev, tbl[i].ew,
                           tbl[i].el, tbl[i].eo, tbl[i].ec);
            end
        end
    endtask

    // Consume n words with word_ready held; words_left starts at start_left.
    task automatic drain(input int n, input int pid, input int first_k, input int start_left,
                         input logic eo, input int ec);
        int left;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 0, 1'b1);
            left = start_left - 1 - i;
            expect_out($sformatf("drain p%0d i%0d", pid, i), left > 0,
                       (left > 0) ? exp_word(pid, first_k + i + 1) : 32'h0, left, eo, ec);
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 16; k++)
                pools[p][k*32 +: 32] = exp_word(p, k);

        add(1, 0, 0, 0, 1,  0, 32'h0,         0,  0, 0); // 0 reset
        add(0, 1, 0, 1, 1,  1, 32'h0,         16, 0, 1); // 1 capture A
        add(0, 1, 1, 0, 1,  1, 32'hB000_0000, 16, 0, 2); // 2 capture B
        add(0, 0, 0, 0, 10, 1, 32'hB000_0000, 16, 0, 2); // 3 stall
        add(0, 0, 0, 1, 1,  1, 32'hB000_0001, 15, 0, 2); // 4 single accept
        add(0, 1, 2, 1, 1,  1, 32'hC000_0000, 16, 0, 3); // 5 last consume + new pool
        add(0, 0, 0, 1, 1,  1, 32'hC000_0001, 15, 0, 3); // 6
        add(0, 0, 0, 1, 1,  1, 32'hC000_0002, 14, 0, 3); // 7
        add(0, 0, 0, 1, 1,  1, 32'hC000_0003, 13, 0, 3); // 8
        add(0, 1, 0, 0, 1,  1, 32'h0,         16, 1, 4); // 9 overrun
        add(0, 0, 0, 1, 1,  1, 32'h1,         15, 1, 4); // 10
        add(1, 1, 1, 1, 1,  0, 32'h0,         0,  0, 0); // 11 reset beats pool_ready
        add(0, 0, 0, 0, 1,  0, 32'h0,         0,  0, 0); // 12
        add(0, 1, 1, 0, 1,  1, 32'hB000_0000, 16, 0, 1); // 13
        add(0, 1, 2, 0, 1,  1, 32'hC000_0000, 16, 1, 2); // 14 last word unconsumed
        add(0, 0, 0, 1, 1,  1, 32'hC000_0001, 15, 1, 2); // 15

        reset2 = 1'b1;
        run_rows(0, 1);
        reset2 = 1'b0;
        drain(16, 0, 0, 16, 1'b0, 1);
        check("sreg zero after drain", 64'(dut.u_shift_reg.r_sreg == '0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 0, 1'b1);
            expect_out($sformatf("underflow %0d", i), 1'b0, 32'h0, 0, 1'b0, 1);
        end
        run_rows(2, 4);
        drain(14, 1, 1, 15, 1'b0, 2);
        run_rows(5, 10);
        drain(8, 0, 1, 15, 1'b1, 4);
        run_rows(11, 11);
        check("sreg zero after reset", 64'(dut.u_shift_reg.r_sreg == '0), 64'd1);
        run_rows(12, 13);
        drain(15, 1, 0, 16, 1'b0, 1);
        run_rows(14, 15);

        for (int i = 1; i <= 20; i++) begin
            pool_ready2 = 1'b1;
            @(posedge clock);
            #1;
            pool_ready2 = 1'b0;
            @(posedge clock);
            #1;
            check($sformatf("saturate %0d", i), 64'(pools_received2), 64'((i < 15) ? i : 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/random_pool_reader.md
Name: random_pool_reader

Overview:
- Consumer end of the XOR randomness extractor.
- Captures the extractor's 512-bit pool on its one-cycle ready pulse.
- Serves the pool to downstream logic (key/nonce generation) as WORD_WIDTH-bit words over a valid/ready stream.
- Zeroizes consumed bits so no random bit is ever delivered twice; flags when the pool is exhausted or replaced before being fully consumed.

Parameters:
- POOL_WIDTH, 512, width of captured pool; must be an integer multiple of WORD_WIDTH.
- WORD_WIDTH, 32, width of each delivered word.
- CNT_WIDTH, 16, width of the pools-received statistics counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pool_ready  input  1  one-cycle pulse from extractor; pool is valid in that cycle.
- pool  input  POOL_WIDTH  extractor buffer contents.
- word_valid  output  1  word holds an unconsumed random word.
- word_ready  input  1  consumer accepts word this cycle.
- word  output  WORD_WIDTH  current random word.
- words_left  output  clog2(POOL_WIDTH/WORD_WIDTH)+1  unconsumed words remaining.
- empty  output  1  no unconsumed words (equals ~word_valid).
- overrun  output  1  sticky: a pool was replaced while words remained.
- pools_received  output  CNT_WIDTH  saturating count of captured pools.

Behaviour:
- Reset, synchronous and active-high: shift register cleared to 0, words_left=0, word_valid=0, word=0, empty=1, overrun=0, pools_received=0. Reset has priority over all other events, including a coincident pool_ready.
- Storage: POOL_WIDTH shift register sreg. The word output is sreg[WORD_WIDTH-1:0], registered, with no combinational path from inputs.
- State machine, two states:
  - EMPTY: words_left==0.
  - LOADED: words_left>0.
  - word_valid = (state==LOADED).
- Capture, any state: on pool_ready, sreg<=pool and words_left<=POOL_WIDTH/WORD_WIDTH at the next edge. Latency is 1 cycle: pool_ready at edge t gives word_valid=1 and word=pool[WORD_WIDTH-1:0] after edge t.
- Consume: when word_valid & word_ready and no pool_ready in the same cycle:
  - sreg <= sreg >> WORD_WIDTH, zero-filled at the top.
  - words_left decrements.
  - The last word (words_left==1) moves the block to EMPTY, with sreg all zero.
- Simultaneous pool_ready and consume: capture wins. The consumed word counts as delivered. The new pool loads whole, words_left=full, and the new pool is not shifted.
- Overrun: set when pool_ready arrives while words_left>1. It is also set when words_left==1 and that last word is not consumed in the same cycle. Once set it stays 1 until reset. The remaining old words are discarded, never delivered.
- pools_received increments on each pool_ready and saturates at all-ones.
- word_ready while EMPTY is ignored: no state change and no underflow.
- word_valid never drops without a handshake or reset; word is stable while word_valid & ~word_ready, unless pool_ready replaces it.
- No bit of a captured pool is ever output twice. Consumed positions hold zero.

Decomposition:
- Shared package holds:
  - POOL_WIDTH_DEFAULT=512 and WORD_WIDTH_DEFAULT=32, also used by the extractor.
  - WORDS_PER_POOL.
  - The state encoding: EMPTY=1'b0, LOADED=1'b1.
- One natural sub-module: pool_shift_reg, the load/shift/zero-fill register holding sreg and words_left. The top level holds the FSM, overrun flag, stats counter and handshake.

Test Plan:
- Capture and drain:
  - Stimulus: reset, then pool_ready with pool = {16 words 32'h0000_000F down to 32'h0000_0000}, i.e. word k = k; hold word_ready=1.
  - Required: word_valid rises 1 cycle after the pulse; words 0,1,…,15 appear on consecutive cycles; words_left counts 16→0; empty=1 after the 16th; sreg all zero; pools_received=1; overrun=0.
- Backpressure:
  - Stimulus: load pool, word_ready=0 for 10 cycles, then a single-cycle accept.
  - Required: word holds pool[31:0] and words_left=16 throughout the stall; after the accept, word=pool[63:32] and words_left=15.
- Overrun:
  - Stimulus: load pool A, consume 3 words, pulse pool_ready with pool B.
  - Required: the next word is B[31:0], words_left=16, overrun=1 and stays 1 after B drains; pools_received=2.
- Coincident last consume and new pool:
  - Stimulus: words_left=1, word_ready=1 and pool_ready in the same cycle.
  - Required: the old last word is delivered; the next word is B[31:0]; words_left=16; overrun stays 0.
- Underflow and reset:
  - Stimulus: word_ready=1 while EMPTY for 5 cycles.
  - Required: word_valid=0 and words_left=0 throughout.
  - Stimulus: assert reset mid-drain (words_left=7), with pool_ready coincident.
  - Required: all outputs return to reset values the next cycle and the pool is not captured.
- Counter saturation:
  - Stimulus: CNT_WIDTH=4 build, 20 pool_ready pulses.
  - Required: pools_received=15 and held at 15.
